run_controller: RTL and testbench

RUN_CONTROLLER -- requirements
Module: run_controller

---
 rtl/run_controller.sv | 118 +++++++++++
 tb/tb_run_controller.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
// Run sequencer for a small core: clears the core, lets it run until it halts
// or the watchdog expires, then reports completion until the host drops req.
module run_controller #(
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 50000,
  parameter int CLR_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             halt,
  output logic             core_clr,
  output logic             core_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles
);

  localparam int               CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  localparam logic [CLR_W-1:0] CLR_ONE  = CLR_W'(1);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CLR_W-1:0] clr_cnt_r;
  logic [CLR_W-1:0] clr_cnt_s;
  logic [CNT_W-1:0] cycles_s;
  logic             timeout_s;

  // Next-state, clear-phase counter, run counter and watchdog flag
  always_comb begin
    state_s   = state_r;
    clr_cnt_s = clr_cnt_r;
    cycles_s  = cycles;
    timeout_s = timeout;
    case (state_r)
      IDLE: begin
        if (req) begin
          state_s   = CLEAR;
          clr_cnt_s = {CLR_W{1'b0}};
          cycles_s  = {CNT_W{1'b0}};
          timeout_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        if (clr_cnt_r == CLR_LAST) begin
          state_s   = RUN;
          clr_cnt_s = {CLR_W{1'b0}};
        end else begin
          clr_cnt_s = clr_cnt_r + CLR_ONE;
        end
      end
      RUN: begin
        // Saturating count; the watchdog exit below keeps it at or under MAX_C
        if (cycles != MAX_C) begin
          cycles_s = cycles + CNT_ONE;
        end else begin
          cycles_s = cycles;
        end
        if (halt) begin
          state_s   = DONE;
          timeout_s = 1'b0;
        end else if ((cycles + CNT_ONE) == MAX_C) begin
          state_s   = DONE;
          timeout_s = 1'b1;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (!req) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered Moore outputs; reset aborts any run immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      clr_cnt_r <= {CLR_W{1'b0}};
      cycles    <= {CNT_W{1'b0}};
      timeout   <= 1'b0;
      core_clr  <= 1'b0;
      core_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_s;
      clr_cnt_r <= clr_cnt_s;
      cycles    <= cycles_s;
      timeout   <= timeout_s;
      core_clr  <= (state_s == CLEAR);
      core_en   <= (state_s == RUN);
      busy      <= (state_s == CLEAR) || (state_s == RUN);
      done      <= (state_s == DONE);
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: directed scenarios with literal
// expectations, then randomized req/halt/reset against a behavioural model.
module tb_run_controller;

  localparam int CNT_W = 8;
  localparam int MAXC  = 8;
  localparam int CLRC  = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             req;
  logic             halt;
  logic             core_clr, core_en, busy, done, timeout;
  logic [CNT_W-1:0] cycles;

  int errors = 0;
  int checks = 0;

  // Per-scenario sample counters, fed by the compare process
  int clr_hi_cnt = 0;
  int en_hi_cnt  = 0;

  // Behavioural model: remaining clear cycles, running flag, run count
  int m_clr_left = 0;
  int m_cyc      = 0;
  bit m_run      = 1'b0;
  bit m_done     = 1'b0;
  bit m_to       = 1'b0;

  run_controller #(.CNT_W(CNT_W), .MAX_CYCLES(MAXC), .CLR_CYCLES(CLRC)) dut (
    .clk(clk), .reset(reset), .req(req), .halt(halt),
    .core_clr(core_clr), .core_en(core_en), .busy(busy),
    .done(done), .timeout(timeout), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_clr_left = 0; m_cyc = 0; m_run = 1'b0; m_done = 1'b0; m_to = 1'b0;
    end else if (m_clr_left > 0) begin
      m_clr_left = m_clr_left - 1;
      if (m_clr_left == 0) m_run = 1'b1;
    end else if (m_run) begin
      m_cyc = m_cyc + 1;
      if (halt) begin
        m_run = 1'b0; m_done = 1'b1; m_to = 1'b0;
      end else if (m_cyc == MAXC) begin
        m_run = 1'b0; m_done = 1'b1; m_to = 1'b1;
      end
    end else if (m_done) begin
      if (!req) m_done = 1'b0;
    end else if (req) begin
      m_clr_left = CLRC; m_cyc = 0; m_to = 1'b0;
    end
  end

  // Compare every cycle, mid-period
  always @(negedge clk) begin
    check("core_clr", int'(core_clr), int'(m_clr_left > 0));
    check("core_en",  int'(core_en),  int'(m_run));
    check("busy",     int'(busy),     int'((m_clr_left > 0) || m_run));
    check("done",     int'(done),     int'(m_done));
    check("timeout",  int'(timeout),  int'(m_to));
    check("cycles",   int'(cycles),   m_cyc);
    if (core_clr) clr_hi_cnt++;
    if (core_en)  en_hi_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_en(input string name);
    int k = 0;
    while (!core_en && k < 20) begin step(1); k++; end
    if (!core_en) check({name, "_en_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 40) begin step(1); k++; end
    if (!done) check({name, "_done_timeout"}, 0, 1);
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; halt = 1'b0;
    #3;
    check("rst_busy", int'(busy), 0);
    check("rst_cycles", int'(cycles), 0);
    check("rst_done", int'(done), 0);
    step(2);
    reset = 1'b1;
    step(2);

    // Basic run: halt sampled at the 5th RUN edge
    clr_hi_cnt = 0; en_hi_cnt = 0;
    req = 1'b1;
    wait_en("basic");
    step(4);
    halt = 1'b1;
    step(1);
    halt = 1'b0;
    check("basic_done", int'(done), 1);
    check("basic_cycles", int'(cycles), 5);
    check("basic_timeout", int'(timeout), 0);
    check("basic_clr_len", clr_hi_cnt, 2);
    check("basic_en_len", en_hi_cnt, 5);

    // Handshake: req held high keeps DONE
    step(4);
    check("hold_done", int'(done), 1);
    check("hold_busy", int'(busy), 0);
    req = 1'b0;
    step(1);
    check("idle_done", int'(done), 0);
    check("idle_cycles", int'(cycles), 5);
    req = 1'b1;
    step(1);
    check("restart_clr", int'(core_clr), 1);
    check("restart_cycles", int'(cycles), 0);

    // Ignored inputs: halt during CLEAR, req low during RUN
    halt = 1'b1;
    step(2);
    halt = 1'b0;
    check("ign_en", int'(core_en), 1);
    req = 1'b0;
    step(2);
    req = 1'b1;
    step(1);
    check("ign_busy", int'(busy), 1);
    halt = 1'b1;
    step(1);
    halt = 1'b0;
    check("ign_cycles", int'(cycles), 4);
    check("ign_done", int'(done), 1);
    req = 1'b0;
    step(1);

    // Watchdog
    clr_hi_cnt = 0; en_hi_cnt = 0;
    req = 1'b1;
    wait_done("wdog");
    check("wdog_cycles", int'(cycles), 8);
    check("wdog_timeout", int'(timeout), 1);
    check("wdog_en", int'(core_en), 0);
    check("wdog_en_len", en_hi_cnt, 8);
    req = 1'b0;
    step(1);

    // Tie: halt and limit on the same edge
    req = 1'b1;
    wait_en("tie");
    step(7);
    halt = 1'b1;
    step(1);
    halt = 1'b0;
    check("tie_done", int'(done), 1);
    check("tie_cycles", int'(cycles), 8);
    check("tie_timeout", int'(timeout), 0);
    req = 1'b0;
    step(1);

    // Reset between edges mid-run
    req = 1'b1;
    wait_en("rst");
    step(2);
    #1 reset = 1'b0;
    #1;
    check("rstmid_en", int'(core_en), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_cycles", int'(cycles), 0);
    step(1);
    reset = 1'b1;
    req = 1'b0;
    step(1);
    check("rstmid_idle", int'(busy), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      req  = ($urandom_range(0, 9) < 7);
      halt = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 199) == 0) begin
        #1 reset = 1'b0;
        step(1);
        reset = 1'b1;
      end else begin
        step(1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
